// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register numbers, exception codes, FSM states.
package cp0_pkg;

    // CP0 register numbers reachable through MFC0/MTC0
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Exception cause codes raised by the pipeline
    localparam logic [4:0] EXC_DIV0    = 5'd1;
    localparam logic [4:0] EXC_ILLEGAL = 5'd2;
    localparam logic [4:0] EXC_MEMERR  = 5'd3;

    // Status bit positions
    localparam int STATUS_IE_BIT  = 0;
    localparam int STATUS_EXL_BIT = 1;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_TRAP    = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } cp0_state_e;

    // Assemble the architectural Cause word from its stored fields
    function automatic logic [31:0] cause_word(input logic bd, input logic [4:0] code);
        cause_word = {bd, 24'd0, code, 2'b00};
    endfunction

endpackage

// File: rtl/cp0_regfile.sv
// CP0 register storage: BadVAddr, Status, Cause, EPC with write arbitration and read mux.
module cp0_regfile
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_take,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_bd,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret_take,
    input  logic        mtc0_take,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [31:0] epc,
    output logic        exl
);

    logic [31:0] badvaddr_q, badvaddr_d;
    logic [1:0]  status_q, status_d;
    logic        cause_bd_q, cause_bd_d;
    logic [4:0]  cause_code_q, cause_code_d;
    logic [31:0] epc_q, epc_d;

    // Next-state: an exception overrides any MTC0/ERET update in the same cycle
    always_comb begin
        badvaddr_d   = badvaddr_q;
        status_d     = status_q;
        cause_bd_d   = cause_bd_q;
        cause_code_d = cause_code_q;
        epc_d        = epc_q;
        if (exc_take) begin
            cause_code_d             = exc_code;
            cause_bd_d               = exc_bd;
            status_d[STATUS_EXL_BIT] = 1'b1;
            if (exc_code == EXC_MEMERR)
                badvaddr_d = exc_badvaddr;
            // A nested exception keeps the original return address
            if (!status_q[STATUS_EXL_BIT])
                epc_d = exc_bd ? (exc_pc - 32'd4) : exc_pc;
        end else begin
            if (mtc0_take) begin
                case (addr)
                    CP0_STATUS: status_d = wdata[1:0];
                    CP0_EPC:    epc_d    = wdata;
                    default:    ;
                endcase
            end
            // ERET clearing EXL takes priority over a simultaneous MTC0 to Status
            if (eret_take)
                status_d[STATUS_EXL_BIT] = 1'b0;
        end
    end

    // Register update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            badvaddr_q   <= '0;
            status_q     <= '0;
            cause_bd_q   <= 1'b0;
            cause_code_q <= '0;
            epc_q        <= '0;
        end else begin
            badvaddr_q   <= badvaddr_d;
            status_q     <= status_d;
            cause_bd_q   <= cause_bd_d;
            cause_code_q <= cause_code_d;
            epc_q        <= epc_d;
        end
    end

    // MFC0 read mux; unmapped numbers read as zero
    always_comb begin
        rdata = '0;
        case (addr)
            CP0_BADVADDR: rdata = badvaddr_q;
            CP0_STATUS:   rdata = {30'd0, status_q};
            CP0_CAUSE:    rdata = cause_word(cause_bd_q, cause_code_q);
            CP0_EPC:      rdata = epc_q;
            default:      rdata = '0;
        endcase
    end

    assign epc = epc_q;
    assign exl = status_q[STATUS_EXL_BIT];

endmodule

// File: rtl/cp0_exception_ctrl.sv
// CP0 exception control: trap/return FSM, flush counter and fetch redirect.
module cp0_exception_ctrl
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = 32'h80000180,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_pc,
    input  logic        exc_in_delay_slot,
    input  logic [31:0] exc_badvaddr,
    input  logic        eret,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        exl
);

    localparam logic [3:0] FLUSH_CNT = FLUSH_CYCLES[3:0];

    cp0_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] target_q, target_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        accepting;
    logic        exc_take, eret_take, mtc0_take;
    logic [31:0] epc_cur;

    // Requests are only honoured outside the flush windows; exception beats ERET and MTC0
    assign accepting = (state_q == ST_NORMAL) || (state_q == ST_HANDLER);
    assign exc_take  = accepting && exc_req;
    assign eret_take = (state_q == ST_HANDLER) && eret && !exc_req;
    assign mtc0_take = accepting && cp0_we && !exc_req;

    cp0_regfile u_regfile (
        .clk          (clk),
        .reset_n      (reset_n),
        .exc_take     (exc_take),
        .exc_code     (exc_code),
        .exc_pc       (exc_pc),
        .exc_bd       (exc_in_delay_slot),
        .exc_badvaddr (exc_badvaddr),
        .eret_take    (eret_take),
        .mtc0_take    (mtc0_take),
        .addr         (cp0_addr),
        .wdata        (cp0_wdata),
        .rdata        (cp0_rdata),
        .epc          (epc_cur),
        .exl          (exl)
    );

    // Next-state and outputs: flush counts down, redirect fires on the last flush cycle
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        target_d       = target_q;
        redirect_pc_d  = redirect_pc_q;
        flush          = 1'b0;
        redirect_valid = 1'b0;
        case (state_q)
            ST_NORMAL, ST_HANDLER: begin
                if (exc_take) begin
                    state_d  = ST_TRAP;
                    cnt_d    = FLUSH_CNT;
                    target_d = HANDLER_ADDR;
                end else if (eret_take) begin
                    state_d  = ST_RETURN;
                    cnt_d    = FLUSH_CNT;
                    target_d = epc_cur;
                end
            end
            ST_TRAP, ST_RETURN: begin
                flush = 1'b1;
                if (cnt_q <= 4'd1) begin
                    redirect_valid = 1'b1;
                    redirect_pc_d  = target_q;
                    cnt_d          = 4'd0;
                    state_d        = (state_q == ST_TRAP) ? ST_HANDLER : ST_NORMAL;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = ST_NORMAL;
        endcase
    end

    // State, counter and redirect target registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_NORMAL;
            cnt_q         <= '0;
            target_q      <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            target_q      <= target_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    // During the pulse present the new target; otherwise hold the last one issued
    assign redirect_pc = redirect_valid ? target_q : redirect_pc_q;

endmodule

// File: tb/tb_cp0_exception_ctrl.sv
// Directed self-checking bench for cp0_exception_ctrl.
module tb_cp0_exception_ctrl;

    localparam logic [31:0] HANDLER = 32'h80000180;
    localparam logic [4:0]  A_BADV  = 5'd8;
    localparam logic [4:0]  A_STAT  = 5'd12;
    localparam logic [4:0]  A_CAUSE = 5'd13;
    localparam logic [4:0]  A_EPC   = 5'd14;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_in_delay_slot;
    logic [31:0] exc_badvaddr;
    logic        eret;
    logic        cp0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exl;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [31:0] last_rpc = 32'h0;

    always #5 clk = ~clk;

    cp0_exception_ctrl #(
        .HANDLER_ADDR (HANDLER),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .exc_req           (exc_req),
        .exc_code          (exc_code),
        .exc_pc            (exc_pc),
        .exc_in_delay_slot (exc_in_delay_slot),
        .exc_badvaddr      (exc_badvaddr),
        .eret              (eret),
        .cp0_we            (cp0_we),
        .cp0_addr          (cp0_addr),
        .cp0_wdata         (cp0_wdata),
        .cp0_rdata         (cp0_rdata),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .exl               (exl)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end else begin
            $display("ok   %s: %08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        exc_req           = 1'b0;
        exc_code          = 5'd0;
        exc_pc            = 32'h0;
        exc_in_delay_slot = 1'b0;
        exc_badvaddr      = 32'h0;
        eret              = 1'b0;
        cp0_we            = 1'b0;
        cp0_wdata         = 32'h0;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
        cp0_addr = a;
        #1;
        check_eq(tag, cp0_rdata, exp);
    endtask

    task automatic check_out(input string tag, input logic f, input logic rv,
                             input logic [31:0] rpc, input logic x);
        check_eq({tag, ".flush"}, {31'd0, flush}, {31'd0, f});
        check_eq({tag, ".rv"},    {31'd0, redirect_valid}, {31'd0, rv});
        check_eq({tag, ".rpc"},   redirect_pc, rpc);
        check_eq({tag, ".exl"},   {31'd0, exl}, {31'd0, x});
    endtask

    // Request already driven; walks E+1..E+3, poking ignored requests into the flush window
    task automatic flush_seq(input string tag, input logic [31:0] target, input logic x);
        step();
        clear_inputs();
        check_out({tag, ".e1"}, 1'b1, 1'b0, last_rpc, x);
        exc_req   = 1'b1;
        exc_code  = 5'd2;
        exc_pc    = 32'h00400abc;
        eret      = 1'b1;
        cp0_we    = 1'b1;
        cp0_addr  = A_EPC;
        cp0_wdata = 32'h11111111;
        step();
        clear_inputs();
        check_out({tag, ".e2"}, 1'b1, 1'b1, target, x);
        last_rpc = target;
        step();
        check_out({tag, ".e3"}, 1'b0, 1'b0, last_rpc, x);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        reset_n  = 1'b0;
        cp0_addr = 5'd0;
        clear_inputs();
        repeat (3) step();
        check_out("reset", 1'b0, 1'b0, 32'h0, 1'b0);
        check_reg("reset.epc", A_EPC, 32'h0);
        check_reg("reset.cause", A_CAUSE, 32'h0);
        check_reg("reset.status", A_STAT, 32'h0);
        check_reg("reset.badv", A_BADV, 32'h0);
        reset_n = 1'b1;
        step();

        // Divide-by-zero, not in delay slot
        exc_req = 1'b1; exc_code = 5'd1; exc_pc = 32'h00400010;
        flush_seq("exc1", HANDLER, 1'b1);
        check_reg("exc1.epc", A_EPC, 32'h00400010);
        check_reg("exc1.cause", A_CAUSE, 32'h00000004);
        check_reg("exc1.status", A_STAT, 32'h00000002);

        // MTC0 EPC in handler: same-cycle read sees old value
        cp0_we = 1'b1; cp0_wdata = 32'h00400100; cp0_addr = A_EPC;
        #1;
        check_eq("mtc0.old", cp0_rdata, 32'h00400010);
        step();
        cp0_we = 1'b0;
        check_reg("mtc0.new", A_EPC, 32'h00400100);
        check_eq("mtc0.noflush", {31'd0, flush}, 32'h0);

        // ERET back to written EPC
        eret = 1'b1;
        flush_seq("eret1", 32'h00400100, 1'b0);
        check_reg("eret1.status", A_STAT, 32'h0);
        check_reg("eret1.epc", A_EPC, 32'h00400100);

        // ERET in NORMAL is ignored
        eret = 1'b1;
        step();
        clear_inputs();
        check_out("eret_normal", 1'b0, 1'b0, last_rpc, 1'b0);
        step();
        check_eq("eret_normal.2", {31'd0, flush}, 32'h0);

        // Memory access error in delay slot
        exc_req = 1'b1; exc_code = 5'd3; exc_pc = 32'h00400020;
        exc_in_delay_slot = 1'b1; exc_badvaddr = 32'h10010003;
        flush_seq("exc3", HANDLER, 1'b1);
        check_reg("exc3.epc", A_EPC, 32'h0040001C);
        check_reg("exc3.cause", A_CAUSE, 32'h8000000C);
        check_reg("exc3.badv", A_BADV, 32'h10010003);

        // Nested invalid instruction in handler: EPC and BadVAddr unchanged
        exc_req = 1'b1; exc_code = 5'd2; exc_pc = 32'h00400040;
        exc_badvaddr = 32'hFFFFFFFF;
        flush_seq("nest", HANDLER, 1'b1);
        check_reg("nest.epc", A_EPC, 32'h0040001C);
        check_reg("nest.cause", A_CAUSE, 32'h00000008);
        check_reg("nest.badv", A_BADV, 32'h10010003);

        eret = 1'b1;
        flush_seq("eret2", 32'h0040001C, 1'b0);

        // Exception + ERET + MTC0 together in NORMAL
        exc_req = 1'b1; exc_code = 5'd1; exc_pc = 32'h00400080;
        eret = 1'b1; cp0_we = 1'b1; cp0_wdata = 32'hDEADBEEF; cp0_addr = A_EPC;
        flush_seq("combo", HANDLER, 1'b1);
        check_reg("combo.epc", A_EPC, 32'h00400080);
        check_reg("combo.cause", A_CAUSE, 32'h00000004);
        eret = 1'b1;
        flush_seq("eret3", 32'h00400080, 1'b0);

        // Reset during first TRAP cycle
        exc_req = 1'b1; exc_code = 5'd1; exc_pc = 32'h00400200;
        step();
        clear_inputs();
        reset_n = 1'b0;
        #1;
        check_out("rst_trap", 1'b0, 1'b0, 32'h0, 1'b0);
        check_reg("rst_trap.epc", A_EPC, 32'h0);
        step();
        reset_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (redirect_valid || flush) pulses++;
        end
        check_eq("rst_trap.nopulse", pulses, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cp0_exception_ctrl.md
# cp0_exception_ctrl

Coprocessor-0 exception control for the MIPS pipeline: consumes the exception request and cause code raised by the pipeline's exception detection logic, records EPC/Cause/BadVAddr/Status, flushes the pipeline for a fixed number of cycles and redirects fetch to the handler. On ERET it performs the reverse path, restoring the pipeline to EPC. It also serves MFC0/MTC0 accesses from the execute stage.

## Interface
- HANDLER_ADDR, 32'h80000180, fetch target on exception
- FLUSH_CYCLES, 2, cycles flush is held before redirect (legal range 1..15)
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- exc_req  in  1  exception detected this cycle
- exc_code  in  5  cause code (1 div-by-zero, 2 invalid instr, 3 mem access error)
- exc_pc  in  32  PC of faulting instruction
- exc_in_delay_slot  in  1  faulting instruction sits in a branch delay slot
- exc_badvaddr  in  32  faulting address, meaningful when exc_code=3
- eret  in  1  ERET executing
- cp0_we  in  1  MTC0 write strobe
- cp0_addr  in  5  CP0 register number
- cp0_wdata  in  32  MTC0 data
- cp0_rdata  out  32  MFC0 data, combinational from cp0_addr
- flush  out  1  kill all in-flight pipeline stages
- redirect_valid  out  1  one-cycle pulse: load redirect_pc into PC
- redirect_pc  out  32  fetch target
- exl  out  1  Status.EXL, processor is in the handler

## Operation
- States: NORMAL, TRAP, HANDLER, RETURN.
- NORMAL/HANDLER + exc_req: at the edge write Cause.ExcCode=exc_code, Cause.BD=exc_in_delay_slot, Status.EXL=1; BadVAddr=exc_badvaddr only if exc_code=3. EPC written only if EXL was 0 (no nesting overwrite): exc_pc, or exc_pc-4 (mod 2^32) when in delay slot. Go TRAP.
- HANDLER + eret (exc_req low): Status.EXL=0, go RETURN.
- eret in NORMAL (EXL=0): ignored, no state change.
- exc_req and eret in same cycle: exception wins, eret dropped.
- exc_req with cp0_we in same cycle: MTC0 dropped entirely.
- In TRAP/RETURN all of exc_req, eret, cp0_we are ignored.
- Register map: 8 BadVAddr (read-only), 12 Status (bits[1:0] = EXL, IE writable; rest read 0), 13 Cause (bit31 BD, bits[6:2] ExcCode; read-only), 14 EPC (fully writable). Unmapped addresses read 0, writes dropped.
- MTC0 to Status.EXL in HANDLER does not change FSM state; only ERET leaves HANDLER.

## Timing
- Reset: state NORMAL, all CP0 registers 0, flush=0, redirect_valid=0, redirect_pc=0, exl=0, flush counter 0.
- exc_req sampled at edge E: registers visible in cp0_rdata from E+1; flush=1 for cycles E+1..E+FLUSH_CYCLES; redirect_valid=1 with redirect_pc=HANDLER_ADDR in cycle E+FLUSH_CYCLES; state HANDLER from E+FLUSH_CYCLES+1.
- ERET: same shape, redirect_pc=EPC value at time of ERET, next state NORMAL.
- redirect_pc holds its last value when redirect_valid=0.
- MTC0 takes effect at the edge; MFC0 same-cycle read returns old value.
- reset_n asserted mid-TRAP/RETURN: immediate return to reset values, no redirect pulse.

## Structure
- Package cp0_pkg: register-number constants, exception-code constants, state enum.
- Sub-module cp0_regfile: BadVAddr/Status/Cause/EPC storage, write arbitration, read mux. FSM and flush counter in the top.

## Test plan
- exc_req, code=1, exc_pc=32'h00400010, no BD, FLUSH_CYCLES=2 -> flush 2 cycles, redirect 32'h80000180 on 2nd, EPC=32'h00400010, Cause=32'h00000004, exl=1.
- code=3, exc_pc=32'h00400020, BD=1, badvaddr=32'h10010003 -> EPC=32'h0040001C, Cause=32'h8000000C, BadVAddr=32'h10010003.
- In HANDLER, eret -> flush 2 cycles, redirect to EPC, exl=0, state NORMAL; MTC0 EPC=32'h00400100 first -> redirect 32'h00400100.
- Nested exc_req (code 2) in HANDLER -> ExcCode=2, EPC unchanged, redirect to handler again.
- exc_req+eret+cp0_we same cycle in NORMAL -> exception taken, MTC0 not written, eret ignored; eret alone in NORMAL -> no flush.
- reset_n low during TRAP cycle 1 -> all outputs 0, no redirect_valid pulse afterwards.
